// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter FSM encodings for the shared-ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SGN = 4'd9;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: logic, add/sub, signed compares; nz flags a non-zero result.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic [31:0] result_o,
  output logic        nz_o,
  output logic        ovf_o
);

  logic [31:0] sum;
  logic [31:0] diff;

  always_comb begin
    sum      = src1_i + src2_i;
    diff     = src1_i - src2_i;
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      ALU_AND: result_o = src1_i & src2_i;
      ALU_OR:  result_o = src1_i | src2_i;
      ALU_ADD: begin
        result_o = sum;
        ovf_o    = (src1_i[31] == src2_i[31]) && (sum[31] != src1_i[31]);
      end
      ALU_SUB: begin
        result_o = diff;
        ovf_o    = (src1_i[31] != src2_i[31]) && (diff[31] != src1_i[31]);
      end
      ALU_SLT: result_o = {31'd0, $signed(src1_i) < $signed(src2_i)};
      ALU_SGN: result_o = {31'd0, src1_i[31]};
      ALU_NOR: result_o = ~(src1_i | src2_i);
      default: result_o = '0;
    endcase
    nz_o = |result_o;
  end

endmodule

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin picker: grants the first valid requester at or after ptr_i, wrapping around.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // Distance from the pointer in round-robin order; the smallest valid distance wins.
  function automatic int rr_dist(input int k, input int ptr);
    return (k >= ptr) ? (k - ptr) : (k + NUM_REQ - ptr);
  endfunction

  always_comb begin
    int best;
    best    = NUM_REQ;
    grant_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (valid_i[k] && (rr_dist(k, int'(ptr_i)) < best)) best = rr_dist(k, int'(ptr_i));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_o[k] = valid_i[k] && (rr_dist(k, int'(ptr_i)) == best);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters with round-robin arbitration,
// an optional ownership lock with idle timeout, and a single registered response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int LOCK_TMO = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [4*NUM_REQ-1:0]  req_op_i,
  input  logic [32*NUM_REQ-1:0] req_src1_i,
  input  logic [32*NUM_REQ-1:0] req_src2_i,
  input  logic [NUM_REQ-1:0]    req_lock_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_result_o,
  output logic                  rsp_nz_o,
  output logic [ID_W-1:0]       rsp_id_o
);

  localparam int TMO_W = (LOCK_TMO > 2) ? $clog2(LOCK_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((LOCK_TMO > 0) ? LOCK_TMO - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_SAT  = (LOCK_TMO > 0) ? TMO_LAST : {TMO_W{1'b1}};

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic               rsp_nz_q, rsp_nz_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] rr_grant_vec;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] xfer;
  logic [NUM_REQ-1:0] owner_oh;
  logic               slot_free;
  logic               owner_valid;
  logic               xfer_any;
  logic               sel_lock;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    next_ptr;
  logic [3:0]         alu_op;
  logic [31:0]        alu_src1;
  logic [31:0]        alu_src2;
  logic [31:0]        alu_result;
  logic               alu_nz;
  logic               alu_ovf_unused;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (rr_grant_vec)
  );

  alu u_alu (
    .op_i     (alu_op),
    .src1_i   (alu_src1),
    .src2_i   (alu_src2),
    .result_o (alu_result),
    .nz_o     (alu_nz),
    .ovf_o    (alu_ovf_unused)
  );

  // Ready is held low during reset so nothing is accepted while state is being cleared.
  always_comb begin
    owner_oh = '0;
    sel_id   = '0;
    sel_lock = 1'b0;
    alu_op   = '0;
    alu_src1 = '0;
    alu_src2 = '0;
    next_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == ID_W'(k)) owner_oh[k] = 1'b1;
    end
    owner_valid = |(owner_oh & req_valid_i);
    slot_free   = !rsp_valid_q || rsp_ready_i;
    grant       = (state_q == ST_LOCKED) ? (owner_oh & req_valid_i) : rr_grant_vec;
    req_ready_o = (slot_free && !rst_i) ? grant : '0;
    xfer        = req_valid_i & req_ready_o;
    xfer_any    = |xfer;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_id   = ID_W'(k);
        sel_lock = req_lock_i[k];
        alu_op   = req_op_i[4*k +: 4];
        alu_src1 = req_src1_i[32*k +: 32];
        alu_src2 = req_src2_i[32*k +: 32];
        next_ptr = ID_W'((k + 1) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_nz_d     = rsp_nz_q;
    rsp_id_d     = rsp_id_q;

    if (xfer_any) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_nz_d     = alu_nz;
      rsp_id_d     = sel_id;
      rr_ptr_d     = next_ptr;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      ST_ARB: begin
        if (xfer_any && sel_lock) begin
          state_d = ST_LOCKED;
          owner_d = sel_id;
          tmo_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (owner_valid) begin
          tmo_d = '0;
          if (xfer_any && !sel_lock) state_d = ST_ARB;
        end else if ((LOCK_TMO != 0) && (tmo_q == TMO_LAST)) begin
          state_d = ST_ARB;
          tmo_d   = '0;
        end else if (tmo_q != TMO_SAT) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      tmo_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_nz_q     <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      tmo_q        <= tmo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_nz_q     <= rsp_nz_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_nz_o     = rsp_nz_q;
  assign rsp_id_o     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter: stimulus pushes hand-computed responses into a
// scoreboard queue, a monitor pops and compares them whenever the response channel is valid.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [7:0]  req_op_i;
  logic [63:0] req_src1_i;
  logic [63:0] req_src2_i;
  logic [1:0]  req_lock_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_nz_o;
  logic [0:0]  rsp_id_o;

  logic [3:0]  op_a   [2];
  logic [31:0] s1_a   [2];
  logic [31:0] s2_a   [2];
  logic        lock_a [2];
  logic [31:0] exp_res[2];

  typedef struct packed {
    logic [31:0] result;
    logic        nz;
    logic [0:0]  id;
  } rsp_t;

  rsp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  assign req_op_i   = {op_a[1], op_a[0]};
  assign req_src1_i = {s1_a[1], s1_a[0]};
  assign req_src2_i = {s2_a[1], s2_a[0]};
  assign req_lock_i = {lock_a[1], lock_a[0]};

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ  (2),
    .ID_W     (1),
    .LOCK_TMO (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_src1_i   (req_src1_i),
    .req_src2_i   (req_src2_i),
    .req_lock_i   (req_lock_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_nz_o     (rsp_nz_o),
    .rsp_id_o     (rsp_id_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic setReq(input int k, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic lock, input logic [31:0] res);
    op_a[k]    = op;
    s1_a[k]    = a;
    s2_a[k]    = b;
    lock_a[k]  = lock;
    exp_res[k] = res;
  endtask

  // One cycle: drive, check grants at the falling edge, log expected responses, advance.
  task automatic applyStimulus(input logic [1:0] valid, input logic rsp_rdy,
                               input logic [1:0] exp_ready, input string tag);
    req_valid_i = valid;
    rsp_ready_i = rsp_rdy;
    @(negedge clk);
    checkOutput({tag, ".req_ready"}, 32'(req_ready_o), 32'(exp_ready));
    for (int k = 0; k < 2; k++) begin
      if (valid[k] && exp_ready[k])
        sb_q.push_back('{result: exp_res[k], nz: (exp_res[k] != 32'd0), id: 1'(k)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (!rst_i && rsp_valid_o) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_rsp: got id %0d result 0x%08h, expected no response",
                   rsp_id_o, rsp_result_o);
        end else begin
          exp = sb_q[0];
          checkOutput("rsp_result", rsp_result_o, exp.result);
          checkOutput("rsp_nz", 32'(rsp_nz_o), 32'(exp.nz));
          checkOutput("rsp_id", 32'(rsp_id_o), 32'(exp.id));
          if (rsp_ready_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) setReq(k, ALU_AND, 32'd0, 32'd0, 1'b0, 32'd0);
    rst_i       = 1'b0;
    req_valid_i = 2'b01;
    rsp_ready_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    checkOutput("reset.req_ready", 32'(req_ready_o), 32'd0);
    checkOutput("reset.rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset.rsp_result", rsp_result_o, 32'd0);
    checkOutput("reset.rsp_nz", 32'(rsp_nz_o), 32'd0);
    checkOutput("reset.rsp_id", 32'(rsp_id_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 2'b00;
    rst_i       = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single op");
    setReq(0, ALU_ADD, 32'd5, 32'd7, 1'b0, 32'd12);
    applyStimulus(2'b01, 1'b1, 2'b01, "t1");
    applyStimulus(2'b00, 1'b1, 2'b00, "t1_drain");

    $display("[TB] contention");
    setReq(0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_F000);
    setReq(1, ALU_OR,  32'h0000_000F, 32'h0000_00F0, 1'b0, 32'h0000_00FF);
    applyStimulus(2'b11, 1'b1, 2'b10, "t2_c0");
    applyStimulus(2'b11, 1'b1, 2'b01, "t2_c1");
    applyStimulus(2'b11, 1'b1, 2'b10, "t2_c2");
    applyStimulus(2'b11, 1'b1, 2'b01, "t2_c3");
    applyStimulus(2'b00, 1'b1, 2'b00, "t2_drain");

    $display("[TB] backpressure");
    setReq(1, ALU_NOR, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(2'b10, 1'b1, 2'b10, "t3_first");
    setReq(0, ALU_SGN, 32'hFFFF_FFFD, 32'd0, 1'b0, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0, 2'b00, "t3_hold");
    applyStimulus(2'b11, 1'b1, 2'b01, "t3_release");
    applyStimulus(2'b00, 1'b1, 2'b00, "t3_drain");

    $display("[TB] lock");
    setReq(1, ALU_SUB, 32'd3, 32'd3, 1'b1, 32'd0);
    setReq(0, ALU_ADD, 32'd1, 32'd1, 1'b0, 32'd2);
    applyStimulus(2'b11, 1'b1, 2'b10, "t4_sub");
    applyStimulus(2'b01, 1'b1, 2'b00, "t4_wait");
    setReq(1, ALU_SLT, 32'hFFFF_FFFC, 32'd2, 1'b0, 32'd1);
    applyStimulus(2'b11, 1'b1, 2'b10, "t4_slt");
    applyStimulus(2'b01, 1'b1, 2'b01, "t4_req0");
    applyStimulus(2'b00, 1'b1, 2'b00, "t4_drain");

    $display("[TB] lock timeout");
    setReq(0, ALU_OR, 32'd1, 32'd2, 1'b1, 32'd3);
    applyStimulus(2'b01, 1'b1, 2'b01, "t5_lock");
    setReq(1, ALU_AND, 32'd6, 32'd3, 1'b0, 32'd2);
    for (int i = 0; i < 4; i++) applyStimulus(2'b10, 1'b1, 2'b00, "t5_idle");
    applyStimulus(2'b10, 1'b1, 2'b10, "t5_grant");
    applyStimulus(2'b00, 1'b1, 2'b00, "t5_drain");

    $display("[TB] reset mid-op");
    setReq(0, ALU_ADD, 32'd100, 32'hFFFF_FFFF, 1'b1, 32'd99);
    applyStimulus(2'b01, 1'b1, 2'b01, "t6_lock");
    setReq(1, ALU_ADD, 32'd2, 32'd2, 1'b0, 32'd4);
    req_valid_i = 2'b10;
    rst_i       = 1'b1;
    #1;
    checkOutput("t6.rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("t6.rst_rsp_result", rsp_result_o, 32'd0);
    checkOutput("t6.rst_rsp_nz", 32'(rsp_nz_o), 32'd0);
    checkOutput("t6.rst_rsp_id", 32'(rsp_id_o), 32'd0);
    checkOutput("t6.rst_req_ready", 32'(req_ready_o), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    applyStimulus(2'b10, 1'b1, 2'b10, "t6_after");
    applyStimulus(2'b00, 1'b1, 2'b00, "t6_drain");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
